// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Shares the CPU's single external memory bus between the instruction-fetch
// unit and the execute unit. Each granted transaction runs through four
// phases: IDLE (grant), ADDR (address setup), STROBE (WAIT_STATES+1 cycles)
// and ACK (one-cycle completion pulse to the winner).
//
// Build option:
//   BUS_ARB_RR_EN  defined   -> round-robin on ties; a last-grant register
//                               starts at FETCH, so data wins the first tie.
//                  undefined -> fixed priority; data always beats fetch.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_ack)
//   if_ack/if_rdata             fetch completion pulse and read byte
//   d_req/d_we/d_sel/d_addr     data request; we=1 write, sel=1 RAM
//   d_wdata                     write byte
//   d_ack/d_rdata               data completion pulse and read byte
//   addr_bus/memory_select      external address and ROM(0)/RAM(1) select
//   read_en/write_en            external strobes
//   bus_din/bus_dout/bus_oe     split tristate data bus
//   busy                        high whenever the FSM is not in IDLE
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] addr_bus,
  output logic              memory_select,
  output logic              read_en,
  output logic              write_en,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_oe,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    STROBE,
    ACK
  } state_t;

  localparam logic [3:0] STROBE_CNT = 4'(WAIT_STATES);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       gnt_data;
  logic       lat_we;
  logic       grant_data;
  logic       any_req;
  logic       wr_ram;

  assign any_req = if_req | d_req;

`ifdef BUS_ARB_RR_EN
  // Remembers who won the most recent grant so a tie goes to the other side.
  logic last_data;

  always_comb begin
    grant_data = d_req;
    if (if_req && d_req) begin
      grant_data = ~last_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_data <= grant_data;
    end
  end
`else
  // Data always wins; a lone fetch request is granted only when d_req is low.
  assign grant_data = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADDR;
      ADDR:    state_next = STROBE;
      STROBE:  if (wait_cnt == 4'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The address/select registers double as the latched transaction fields, so
  // they naturally hold their last value between transactions. bus_dout only
  // loads for a real RAM write; ROM writes and reads leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_data      <= 1'b0;
      lat_we        <= 1'b0;
      addr_bus      <= '0;
      memory_select <= 1'b0;
      bus_dout      <= '0;
      wait_cnt      <= 4'd0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_data      <= grant_data;
            lat_we        <= grant_data & d_we;
            memory_select <= grant_data & d_sel;
            addr_bus      <= grant_data ? d_addr : if_addr;
            if (grant_data && d_we && d_sel) begin
              bus_dout <= d_wdata;
            end
          end
        end
        ADDR: begin
          wait_cnt <= STROBE_CNT;
        end
        STROBE: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!lat_we) begin
            if (gnt_data) begin
              d_rdata <= bus_din;
            end else begin
              if_rdata <= bus_din;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A write aimed at ROM still runs the full sequence but never drives the bus.
  assign wr_ram   = lat_we & memory_select;
  assign busy     = (state != IDLE);
  assign read_en  = (state == STROBE) & ~lat_we;
  assign write_en = (state == STROBE) & wr_ram;
  assign bus_oe   = ((state == ADDR) | (state == STROBE)) & wr_ram;
  assign if_ack   = (state == ACK) & ~gnt_data;
  assign d_ack    = (state == ACK) & gnt_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios with literal expectations
// plus a randomized phase compared every cycle against a transaction-timeline
// model (cycles elapsed since grant). A second instance with WAIT_STATES=0
// covers the shortest strobe.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WS = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic          d_sel = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] addr_bus;
  logic          memory_select;
  logic          read_en;
  logic          write_en;
  logic [DW-1:0] bus_din = '0;
  logic [DW-1:0] bus_dout;
  logic          bus_oe;
  logic          busy;

  logic          z_if_req = 1'b0;
  logic [AW-1:0] z_if_addr = '0;
  logic          z_if_ack;
  logic [DW-1:0] z_if_rdata;
  logic          z_d_req = 1'b0;
  logic          z_d_we = 1'b0;
  logic          z_d_sel = 1'b0;
  logic [AW-1:0] z_d_addr = '0;
  logic [DW-1:0] z_d_wdata = '0;
  logic          z_d_ack;
  logic [DW-1:0] z_d_rdata;
  logic [AW-1:0] z_addr_bus;
  logic          z_memory_select;
  logic          z_read_en;
  logic          z_write_en;
  logic [DW-1:0] z_bus_din = '0;
  logic [DW-1:0] z_bus_dout;
  logic          z_bus_oe;
  logic          z_busy;

  int checks_total  = 0;
  int checks_passed = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .addr_bus(addr_bus), .memory_select(memory_select),
    .read_en(read_en), .write_en(write_en),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .busy(busy)
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_sel(z_d_sel), .d_addr(z_d_addr),
    .d_wdata(z_d_wdata), .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .addr_bus(z_addr_bus), .memory_select(z_memory_select),
    .read_en(z_read_en), .write_en(z_write_en),
    .bus_din(z_bus_din), .bus_dout(z_bus_dout), .bus_oe(z_bus_oe), .busy(z_busy)
  );

  // Reference model: a transaction is described only by who won, what was
  // latched, and how many cycles have elapsed since the grant (m_t=1 is the
  // address cycle, 2..2+WS are strobe cycles, 3+WS is the ack cycle).
  bit          m_busy = 1'b0;
  int          m_t = 0;
  bit          m_gnt_data = 1'b0;
  bit          m_we = 1'b0;
  bit          m_msel = 1'b0;
  bit          m_last_data = 1'b0;
  logic [AW-1:0] m_addr_bus = '0;
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  bit          if_done = 1'b0;
  bit          d_done = 1'b0;

  always @(posedge clk) begin
    bit pick;
    if (rst) begin
      m_busy = 0; m_t = 0; m_gnt_data = 0; m_we = 0; m_msel = 0;
      m_last_data = 0; m_addr_bus = '0; m_dout = '0;
      m_if_rdata = '0; m_d_rdata = '0; if_done = 0; d_done = 0;
    end else begin
      if_done = 0;
      d_done  = 0;
      if (!m_busy) begin
        if (if_req || d_req) begin
`ifdef BUS_ARB_RR_EN
          pick = (if_req && d_req) ? !m_last_data : d_req;
`else
          pick = d_req;
`endif
          m_last_data = pick;
          m_gnt_data  = pick;
          m_we        = pick && d_we;
          m_msel      = pick && d_sel;
          m_addr_bus  = pick ? d_addr : if_addr;
          if (pick && d_we && d_sel) m_dout = d_wdata;
          m_busy = 1;
          m_t    = 1;
        end
      end else begin
        if (m_t == 2 + WS && !m_we) begin
          if (m_gnt_data) m_d_rdata = bus_din;
          else            m_if_rdata = bus_din;
        end
        if (m_t == 3 + WS) begin
          m_busy = 0;
          if (m_gnt_data) d_done = 1;
          else            if_done = 1;
        end
        m_t++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    bit strobe, e_oe, e_ack;
    if (cmp_en) begin
      strobe = m_busy && m_t >= 2 && m_t <= 2 + WS;
      e_oe   = m_busy && m_t >= 1 && m_t <= 2 + WS && m_we && m_msel;
      e_ack  = m_busy && m_t == 3 + WS;
      checkOutput("m_busy", 32'(busy), 32'(m_busy));
      checkOutput("m_addr_bus", 32'(addr_bus), 32'(m_addr_bus));
      checkOutput("m_memory_select", 32'(memory_select), 32'(m_msel));
      checkOutput("m_read_en", 32'(read_en), 32'(strobe && !m_we));
      checkOutput("m_write_en", 32'(write_en), 32'(strobe && m_we && m_msel));
      checkOutput("m_bus_oe", 32'(bus_oe), 32'(e_oe));
      checkOutput("m_bus_dout", 32'(bus_dout), 32'(m_dout));
      checkOutput("m_if_ack", 32'(if_ack), 32'(e_ack && !m_gnt_data));
      checkOutput("m_d_ack", 32'(d_ack), 32'(e_ack && m_gnt_data));
      checkOutput("m_if_rdata", 32'(if_rdata), 32'(m_if_rdata));
      checkOutput("m_d_rdata", 32'(d_rdata), 32'(m_d_rdata));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Random requester behaviour: raise a request at random, hold it until the
  // model says it was acked, then maybe keep it high as a fresh request.
  // Address/data fields wander every cycle to exercise grant-time latching.
  task automatic applyStimulus;
    if (!if_req) if_req = ($urandom_range(0, 3) == 0);
    else if (if_done) if_req = ($urandom_range(0, 1) == 1);
    if (!d_req) d_req = ($urandom_range(0, 2) == 0);
    else if (d_done) d_req = ($urandom_range(0, 1) == 1);
    if_addr = AW'($urandom);
    d_addr  = AW'($urandom);
    d_wdata = DW'($urandom);
    d_we    = $urandom_range(0, 1) == 1;
    d_sel   = $urandom_range(0, 1) == 1;
    bus_din = DW'($urandom);
    rst     = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    logic [3:0] order;
    logic [3:0] order_exp;
    bit got;

    rst = 1'b1;
    tick;
    cmp_en = 1'b1;
    tick;
    rst = 1'b0;

    // Reset values
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr_bus", 32'(addr_bus), 32'd0);
    checkOutput("rst_bus_dout", 32'(bus_dout), 32'd0);
    checkOutput("rst_if_rdata", 32'(if_rdata), 32'd0);
    checkOutput("rst_d_rdata", 32'(d_rdata), 32'd0);
    checkOutput("rst_strobes", 32'({read_en, write_en, bus_oe}), 32'd0);
    checkOutput("rst_acks", 32'({if_ack, d_ack}), 32'd0);

    // WAIT_STATES=0 RAM read on the second instance
    z_d_req = 1; z_d_we = 0; z_d_sel = 1; z_d_addr = 16'h0040; z_bus_din = 8'h5A;
    tick;
    checkOutput("z_n1_read_en", 32'(z_read_en), 32'd0);
    checkOutput("z_n1_busy", 32'(z_busy), 32'd1);
    tick;
    checkOutput("z_n2_read_en", 32'(z_read_en), 32'd1);
    checkOutput("z_n2_ack", 32'(z_d_ack), 32'd0);
    tick;
    checkOutput("z_n3_d_ack", 32'(z_d_ack), 32'd1);
    checkOutput("z_n3_d_rdata", 32'(z_d_rdata), 32'h5A);
    checkOutput("z_n3_read_en", 32'(z_read_en), 32'd0);
    z_d_req = 0;
    tick;

    // Fetch read
    if_req = 1; if_addr = 16'h0100; bus_din = 8'hB4;
    tick;
    if_addr = 16'hFFFF;
    checkOutput("f_n1_addr", 32'(addr_bus), 32'h0100);
    checkOutput("f_n1_msel", 32'(memory_select), 32'd0);
    checkOutput("f_n1_read_en", 32'(read_en), 32'd0);
    checkOutput("f_n1_oe", 32'(bus_oe), 32'd0);
    tick;
    checkOutput("f_n2_read_en", 32'(read_en), 32'd1);
    checkOutput("f_n2_oe", 32'(bus_oe), 32'd0);
    tick;
    checkOutput("f_n3_read_en", 32'(read_en), 32'd1);
    checkOutput("f_n3_addr", 32'(addr_bus), 32'h0100);
    tick;
    checkOutput("f_n4_if_ack", 32'(if_ack), 32'd1);
    checkOutput("f_n4_d_ack", 32'(d_ack), 32'd0);
    checkOutput("f_n4_if_rdata", 32'(if_rdata), 32'hB4);
    checkOutput("f_n4_read_en", 32'(read_en), 32'd0);
    if_req = 0;
    tick;
    checkOutput("f_idle_busy", 32'(busy), 32'd0);
    checkOutput("f_idle_addr_hold", 32'(addr_bus), 32'h0100);

    // RAM write
    d_req = 1; d_we = 1; d_sel = 1; d_addr = 16'h0030; d_wdata = 8'h50;
    tick;
    d_wdata = 8'hFF; d_addr = 16'hFFFF;
    checkOutput("w_n1_msel", 32'(memory_select), 32'd1);
    checkOutput("w_n1_oe", 32'(bus_oe), 32'd1);
    checkOutput("w_n1_dout", 32'(bus_dout), 32'h50);
    checkOutput("w_n1_strobes", 32'({read_en, write_en}), 32'd0);
    tick;
    checkOutput("w_n2_write_en", 32'(write_en), 32'd1);
    checkOutput("w_n2_read_en", 32'(read_en), 32'd0);
    tick;
    checkOutput("w_n3_write_en", 32'(write_en), 32'd1);
    checkOutput("w_n3_oe", 32'(bus_oe), 32'd1);
    checkOutput("w_n3_dout", 32'(bus_dout), 32'h50);
    checkOutput("w_n3_addr", 32'(addr_bus), 32'h0030);
    tick;
    checkOutput("w_n4_d_ack", 32'(d_ack), 32'd1);
    checkOutput("w_n4_oe", 32'(bus_oe), 32'd0);
    checkOutput("w_n4_d_rdata", 32'(d_rdata), 32'd0);
    d_req = 0;
    tick;
    checkOutput("w_idle_dout_hold", 32'(bus_dout), 32'h50);

    // ROM write: sequence runs, bus never driven
    d_req = 1; d_we = 1; d_sel = 0; d_addr = 16'h0200; d_wdata = 8'h77;
    for (int c = 1; c <= 3; c++) begin
      tick;
      checkOutput("rw_write_en", 32'(write_en), 32'd0);
      checkOutput("rw_oe", 32'(bus_oe), 32'd0);
      checkOutput("rw_msel", 32'(memory_select), 32'd0);
    end
    tick;
    checkOutput("rw_n4_d_ack", 32'(d_ack), 32'd1);
    checkOutput("rw_n4_dout", 32'(bus_dout), 32'h50);
    d_req = 0; d_we = 0;
    tick;

    // Reset during the first strobe cycle, fetch held throughout
    if_req = 1; if_addr = 16'h0ABC;
    tick;
    tick;
    checkOutput("r_strobe_read_en", 32'(read_en), 32'd1);
    rst = 1;
    tick;
    rst = 0;
    checkOutput("r_after_read_en", 32'(read_en), 32'd0);
    checkOutput("r_after_busy", 32'(busy), 32'd0);
    checkOutput("r_after_ack", 32'({if_ack, d_ack}), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick;
      checkOutput("r_wait_if_ack", 32'(if_ack), 32'd0);
    end
    tick;
    checkOutput("r_reserve_if_ack", 32'(if_ack), 32'd1);
    if_req = 0;
    tick;

    // Both requests held for four transactions, fresh from reset
    rst = 1;
    tick;
    rst = 0;
    if_req = 1; d_req = 1; d_we = 0; d_sel = 1;
    order = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 10; c++) begin
        tick;
        if (if_ack || d_ack) begin
          order[k] = d_ack;
          got = 1;
          break;
        end
      end
      if (!got) begin
        checkOutput("arb_ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
`ifdef BUS_ARB_RR_EN
    order_exp = 4'b0101;
`else
    order_exp = 4'b1111;
`endif
    checkOutput("arb_grant_order", 32'(order), 32'(order_exp));
    if_req = 0; d_req = 0;
    tick;
    tick;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick;
    end

    rst = 0; if_req = 0; d_req = 0;
    tick;
    tick;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the CPU's single external memory bus between two requesters: the instruction-fetch unit (program ROM reads) and the execute unit (data RAM read/write, MOVC-style ROM reads). It sequences each bus transaction through address, strobe and acknowledge phases with configurable wait states. It drives addr_bus, read_en, write_en and memory_select. The tristate data_bus is split into bus_din, bus_dout and bus_oe, and the CPU top resolves them to the pad.

Parameters:
ADDR_W, 16, address width.
DATA_W, 8, data width.
WAIT_STATES, 1, extra strobe cycles. Strobe length is WAIT_STATES+1 cycles. Legal range is 0..15.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset, synchronous, active-high.
if_req  in  1  fetch request; held until if_ack.
if_addr  in  ADDR_W  fetch address.
if_ack  out  1  one-cycle completion pulse for the fetch requester.
if_rdata  out  DATA_W  fetched byte; valid while if_ack=1.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 selects a write, 0 selects a read.
d_sel  in  1  0 selects ROM, 1 selects RAM.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  write data.
d_ack  out  1  one-cycle completion pulse for the data requester.
d_rdata  out  DATA_W  read byte; valid while d_ack=1.
addr_bus  out  ADDR_W  external address.
memory_select  out  1  0 selects ROM, 1 selects RAM.
read_en  out  1  read strobe.
write_en  out  1  write strobe.
bus_din  in  DATA_W  data sampled from data_bus.
bus_dout  out  DATA_W  data driven onto data_bus.
bus_oe  out  1  data_bus output enable.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: when rst=1 at a clock edge, the FSM enters IDLE. All outputs are 0, including addr_bus, bus_dout, if_rdata and d_rdata. The last-grant register resets to FETCH.
- Reset mid-transaction: the transaction is abandoned. There is no ack, and the strobes drop at that same edge.
- FSM states are IDLE, ADDR, STROBE and ACK.
- IDLE:
  - If any request is pending, the arbiter grants one requester.
  - At the grant it latches addr, we, sel and wdata. Fetch grants always use we=0 and sel=0.
  - It then moves to ADDR.
  - Requester input changes after the grant are ignored.
- ADDR, one cycle:
  - addr_bus and memory_select take the latched values.
  - For a write, bus_oe=1 and bus_dout=wdata.
  - read_en and write_en stay 0.
- STROBE, WAIT_STATES+1 cycles, timed by a 4-bit down-counter:
  - For a read, read_en=1.
  - For a write, write_en=1 and bus_oe stays 1.
  - On the last STROBE cycle the edge captures bus_din into the granted requester's rdata register. Writes leave rdata unchanged.
- ACK, one cycle:
  - The granted requester's ack=1 and both strobes are 0. bus_oe=0.
  - Next state is always IDLE.
- A req that is still high in IDLE after an ack is treated as a new request.
- Latency: request seen in IDLE at cycle n gives ADDR at n+1, STROBE from n+2 to n+2+WAIT_STATES, and ack at n+3+WAIT_STATES.
- Between transactions, addr_bus and memory_select hold their last values. bus_dout holds its value while bus_oe=0.
- Write to ROM (d_we=1 and d_sel=0): the full sequence runs with memory_select=0, but write_en and bus_oe are never asserted. d_ack is issued at the normal time.
- Reads never assert bus_oe.
- Only one ack is high in any cycle. if_ack and d_ack are never high together.
- Default arbitration is fixed priority: data wins over fetch when both requests are pending in IDLE.

Optional Feature:
Macro: BUS_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are pending in IDLE, the grant goes to the requester that was not granted last. The last-grant register updates at each grant and resets to FETCH, so data wins the first tie. A lone requester is always granted.
- Undefined: fixed priority with data over fetch, and no last-grant register. Fetch can be starved while d_req stays high.

Test Plan:
- Fetch read, WAIT_STATES=1, if_req at n with if_addr=0x0100 and bus_din=0xB4 -> addr_bus=0x0100 and memory_select=0 from n+1; read_en=1 at n+2 and n+3; if_ack=1 at n+4 with if_rdata=0xB4; bus_oe=0 throughout.
- RAM write, d_we=1, d_sel=1, d_addr=0x0030, d_wdata=0x50 -> memory_select=1; bus_oe=1 and bus_dout=0x50 from n+1 to n+3; write_en=1 at n+2 and n+3; read_en=0 throughout; d_ack=1 at n+4.
- Both requests held high for 4 transactions -> without the macro, grant order is D,D,D,D and if_ack never fires; with BUS_ARB_RR_EN, grant order is D,F,D,F.
- ROM write, d_we=1 and d_sel=0 -> write_en=0 and bus_oe=0 throughout; d_ack=1 at n+4.
- rst=1 during the first STROBE cycle -> read_en=0 and busy=0 at the next edge, with no ack; a held if_req after rst=0 is re-served with if_ack 4 cycles after IDLE.
- WAIT_STATES=0 with a RAM read of bus_din=0x5A -> read_en=1 for one cycle at n+2; d_ack=1 with d_rdata=0x5A at n+3.
